// File: rtl/sprite_layer_compositor.sv
// sprite_layer_compositor: picks the highest-priority opaque layer pixel
// (index 0 wins) or the background colour, through a fixed two-register
// pipeline with blanking carried alongside the pixel.
module sprite_layer_compositor #(
  parameter int               N_LAYERS     = 8,
  parameter int               RGB_W        = 12,
  parameter logic [RGB_W-1:0] KEY_RGB      = 12'hF0F,
  parameter int               BLINK_FRAMES = 16,
  localparam int              SRC_W        = $clog2(N_LAYERS + 1)
) (
  input  logic                      i_pclk,
  input  logic                      i_rst,
  input  logic [N_LAYERS*RGB_W-1:0] i_layer_rgb,
  input  logic [N_LAYERS-1:0]       i_layer_hit,
  input  logic [N_LAYERS-1:0]       i_blink_sel,
  input  logic [RGB_W-1:0]          i_bg_rgb,
  input  logic                      i_blank,
  input  logic                      i_vsync,
  input  logic                      i_mask_we,
  input  logic [N_LAYERS-1:0]       i_mask_data,
  output logic [RGB_W-1:0]          o_rgb,
  output logic [SRC_W-1:0]          o_src,
  output logic                      o_blank
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [SRC_W-1:0] SRC_NONE = SRC_W'(N_LAYERS);

  // Layer enable mask and blink state
  logic [N_LAYERS-1:0] mask_q, mask_d;
  logic                vs_q, vs_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                blink_off_q, blink_off_d;

  // Stage 1: per-layer opacity plus the raw colours and blanking
  logic [N_LAYERS-1:0]       s1_opaque_q, s1_opaque_d;
  logic [N_LAYERS*RGB_W-1:0] s1_rgb_q, s1_rgb_d;
  logic [RGB_W-1:0]          s1_bg_q, s1_bg_d;
  logic                      s1_blank_q, s1_blank_d;

  // Stage 2: composited output
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             blank_q, blank_d;

  logic             tick;
  logic             any_opaque;
  logic [SRC_W-1:0] win_idx;
  logic [RGB_W-1:0] win_rgb;

  // Mask load and frame-tick driven blink counter; the two are independent
  always_comb begin
    mask_d      = mask_q;
    vs_d        = i_vsync;
    frame_cnt_d = frame_cnt_q;
    blink_off_d = blink_off_q;
    tick        = i_vsync & ~vs_q;
    if (i_mask_we) begin
      mask_d = i_mask_data;
    end
    if (tick) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: decide which layers are opaque using the mask already in place
  always_comb begin
    s1_opaque_d = '0;
    s1_rgb_d    = i_layer_rgb;
    s1_bg_d     = i_bg_rgb;
    s1_blank_d  = i_blank;
    for (int k = 0; k < N_LAYERS; k++) begin
      s1_opaque_d[k] = i_layer_hit[k] & mask_q[k]
                     & (i_layer_rgb[k*RGB_W +: RGB_W] != KEY_RGB)
                     & ~(i_blink_sel[k] & blink_off_q);
    end
  end

  // Stage 2: lowest opaque index wins; scanning downwards leaves it last
  always_comb begin
    any_opaque = 1'b0;
    win_idx    = SRC_NONE;
    win_rgb    = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (s1_opaque_q[k]) begin
        any_opaque = 1'b1;
        win_idx    = SRC_W'(k);
        win_rgb    = s1_rgb_q[k*RGB_W +: RGB_W];
      end
    end
    blank_d = s1_blank_q;
    if (s1_blank_q) begin
      rgb_d = '0;
      src_d = SRC_NONE;
    end else if (any_opaque) begin
      rgb_d = win_rgb;
      src_d = win_idx;
    end else begin
      rgb_d = s1_bg_q;
      src_d = SRC_NONE;
    end
  end

  // All state registers with synchronous reset
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      mask_q      <= '1;
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
      blink_off_q <= 1'b0;
      s1_opaque_q <= '0;
      s1_rgb_q    <= '0;
      s1_bg_q     <= '0;
      s1_blank_q  <= 1'b1;
      rgb_q       <= '0;
      src_q       <= SRC_NONE;
      blank_q     <= 1'b1;
    end else begin
      mask_q      <= mask_d;
      vs_q        <= vs_d;
      frame_cnt_q <= frame_cnt_d;
      blink_off_q <= blink_off_d;
      s1_opaque_q <= s1_opaque_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_bg_q     <= s1_bg_d;
      s1_blank_q  <= s1_blank_d;
      rgb_q       <= rgb_d;
      src_q       <= src_d;
      blank_q     <= blank_d;
    end
  end

  assign o_rgb   = rgb_q;
  assign o_src   = src_q;
  assign o_blank = blank_q;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// tb_sprite_layer_compositor: streamed vector table for the compositing
// function, plus hand sequences for mask timing, blink and mid-stream reset.
module tb_sprite_layer_compositor;

  logic        i_pclk = 1'b0;
  logic        i_rst;
  logic [95:0] i_layer_rgb;
  logic [7:0]  i_layer_hit;
  logic [7:0]  i_blink_sel;
  logic [11:0] i_bg_rgb;
  logic        i_blank;
  logic        i_vsync;
  logic        i_mask_we;
  logic [7:0]  i_mask_data;
  logic [11:0] o_rgb;
  logic [3:0]  o_src;
  logic        o_blank;

  int n_applied = 0;
  int n_miscompares = 0;

  typedef struct {
    logic [7:0]  hit;
    logic [95:0] rgb;
    logic [11:0] bg;
    logic        blank;
    logic [11:0] exp_rgb;
    logic [3:0]  exp_src;
    logic        exp_blank;
  } vec_t;

  localparam int N_VEC = 10;
  vec_t vecs [N_VEC];

  sprite_layer_compositor #(
    .N_LAYERS(8), .RGB_W(12), .KEY_RGB(12'hF0F), .BLINK_FRAMES(2)
  ) dut (
    .i_pclk(i_pclk), .i_rst(i_rst), .i_layer_rgb(i_layer_rgb),
    .i_layer_hit(i_layer_hit), .i_blink_sel(i_blink_sel), .i_bg_rgb(i_bg_rgb),
    .i_blank(i_blank), .i_vsync(i_vsync), .i_mask_we(i_mask_we),
    .i_mask_data(i_mask_data), .o_rgb(o_rgb), .o_src(o_src), .o_blank(o_blank)
  );

  // Free-running pixel clock
  always #5 i_pclk = ~i_pclk;

  task automatic step();
    @(posedge i_pclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] hit, input logic [95:0] rgb,
                                input logic [11:0] bg, input logic blank);
    i_layer_hit = hit;
    i_layer_rgb = rgb;
    i_bg_rgb    = bg;
    i_blank     = blank;
  endtask

  task automatic check_output(input string tag, input logic [11:0] er,
                              input logic [3:0] es, input logic eb);
    n_applied++;
    if (o_rgb !== er || o_src !== es || o_blank !== eb) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got rgb=%h src=%0d blank=%b, expected rgb=%h src=%0d blank=%b",
               tag, o_rgb, o_src, o_blank, er, es, eb);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    // layer order in the rgb words, MSB first: 7 6 5 4 3 2 1 0
    vecs[0] = '{8'h24, 96'h000_000_456_000_000_123_000_000, 12'h00A, 1'b0, 12'h123, 4'd2, 1'b0};
    vecs[1] = '{8'h24, 96'h000_000_456_000_000_F0F_000_000, 12'h00A, 1'b0, 12'h456, 4'd5, 1'b0};
    vecs[2] = '{8'h04, 96'h000_000_456_000_000_F0F_000_000, 12'h00A, 1'b0, 12'h00A, 4'd8, 1'b0};
    vecs[3] = '{8'h00, 96'h000_000_456_000_000_123_000_000, 12'h0BC, 1'b0, 12'h0BC, 4'd8, 1'b0};
    vecs[4] = '{8'h24, 96'h000_000_456_000_000_123_000_000, 12'h00A, 1'b1, 12'h000, 4'd8, 1'b1};
    vecs[5] = '{8'hFF, 96'h777_666_555_444_333_222_111_ABC, 12'h00A, 1'b0, 12'hABC, 4'd0, 1'b0};
    vecs[6] = '{8'h80, 96'h777_666_555_444_333_222_111_ABC, 12'h00A, 1'b0, 12'h777, 4'd7, 1'b0};
    vecs[7] = '{8'h42, 96'h777_FFF_555_444_333_222_001_ABC, 12'h00A, 1'b0, 12'h001, 4'd1, 1'b0};
    vecs[8] = '{8'h03, 96'h000_000_000_000_000_000_F0E_F0F, 12'h00A, 1'b0, 12'hF0E, 4'd1, 1'b0};
    vecs[9] = '{8'h00, 96'h000_000_000_000_000_000_000_000, 12'h123, 1'b1, 12'h000, 4'd8, 1'b1};

    i_rst = 1'b1;
    i_blink_sel = 8'h00;
    i_vsync = 1'b0;
    i_mask_we = 1'b0;
    i_mask_data = 8'h00;
    apply_stimulus(8'h00, '0, 12'h00A, 1'b0);
    step();
    check_output("reset_state", 12'h000, 4'd8, 1'b1);
    step();
    i_rst = 1'b0;

    // Back-to-back vectors: output after each edge belongs to the previous vector
    for (int i = 0; i <= N_VEC; i++) begin
      if (i < N_VEC) apply_stimulus(vecs[i].hit, vecs[i].rgb, vecs[i].bg, vecs[i].blank);
      else apply_stimulus(8'h00, '0, 12'h00A, 1'b0);
      step();
      if (i >= 1)
        check_output($sformatf("vec%0d", i - 1), vecs[i-1].exp_rgb,
                     vecs[i-1].exp_src, vecs[i-1].exp_blank);
    end

    // Mask write: the pixel sampled in the write cycle still sees the old mask
    apply_stimulus(8'h04, 96'h000_000_000_000_000_123_000_000, 12'h00A, 1'b0);
    step(); step(); step();
    i_mask_we = 1'b1;
    i_mask_data = 8'hFB;
    step();
    i_mask_we = 1'b0;
    step();
    check_output("mask_write_cycle", 12'h123, 4'd2, 1'b0);
    step();
    check_output("mask_applied", 12'h00A, 4'd8, 1'b0);
    i_mask_we = 1'b1;
    i_mask_data = 8'hFF;
    step();
    i_mask_we = 1'b0;
    step();
    check_output("mask_restore_write_cycle", 12'h00A, 4'd8, 1'b0);
    step();
    check_output("mask_restored", 12'h123, 4'd2, 1'b0);

    // Mid-stream reset with a restrictive mask loaded beforehand
    i_mask_we = 1'b1;
    i_mask_data = 8'hFB;
    step();
    i_mask_we = 1'b0;
    step(); step();
    check_output("mask_before_reset", 12'h00A, 4'd8, 1'b0);
    i_rst = 1'b1;
    step();
    check_output("rst_assert", 12'h000, 4'd8, 1'b1);
    i_rst = 1'b0;
    step();
    check_output("rst_first_cycle", 12'h000, 4'd8, 1'b1);
    step();
    check_output("rst_mask_ones", 12'h123, 4'd2, 1'b0);

    // Blink with two frames per half-period: hidden after tick 2, back after tick 4
    do_reset();
    i_blink_sel = 8'h08;
    apply_stimulus(8'h08, 96'h000_000_000_000_333_000_000_000, 12'h00A, 1'b0);
    step(); step(); step();
    check_output("blink_pre", 12'h333, 4'd3, 1'b0);
    for (int p = 1; p <= 4; p++) begin
      i_vsync = 1'b1;
      step(); step(); step();
      i_vsync = 1'b0;
      step(); step(); step();
      if (p == 2 || p == 3)
        check_output($sformatf("blink_tick%0d", p), 12'h00A, 4'd8, 1'b0);
      else
        check_output($sformatf("blink_tick%0d", p), 12'h333, 4'd3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
